mux_arbiter4: RTL and testbench
===============================

MUX_ARBITER4 -- requirements
Module: mux_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4: maximum consecutive grant cycles before forced rotation when another requester waits; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared 4:1 data path.
REQ-005 The block SHALL have port data, input, 4 bits: data[i] is requester i's data bit.
REQ-006 The block SHALL have port grant, output, 4 bits: one-hot owner of the path, or all-zero when there is no owner.
REQ-007 The block SHALL have port select, output, 2 bits: binary index of the owner, driving the 4:1 mux select.
REQ-008 The block SHALL have port valid, output, 1 bit: high when grant is non-zero.
REQ-009 The block SHALL have port out, output, 1 bit: registered data bit of the owner.

Function
REQ-010 The block SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-011 The block SHALL keep internal state: priority pointer ptr (2 bits) and hold counter cnt (4 bits).
REQ-012 All outputs SHALL be registered; grant, select and valid SHALL change only on a clk edge.
REQ-013 From IDLE with req != 0, the block SHALL enter GRANT on the next edge. Winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Set grant=onehot(winner), select=winner, valid=1, cnt=1.
REQ-014 From IDLE with req == 0, the block SHALL remain in IDLE with grant=0, valid=0 and select holding its last value.
REQ-015 In GRANT, owner request held: if cnt < MAX_HOLD, or no other req bit is set, the block SHALL keep the owner and increment cnt, saturating at MAX_HOLD.
REQ-016 In GRANT, owner request held, cnt == MAX_HOLD and another req bit set (forced rotation): the block SHALL grant on the next edge the first requesting i searching owner+1, owner+2, owner+3 (mod 4), with cnt=1.
REQ-017 In GRANT, owner request dropped with other requests pending: the block SHALL grant on the next edge the first requesting i from owner+1 (mod 4), with no idle bubble and cnt=1.
REQ-018 In GRANT, owner request dropped with no requests pending: the block SHALL go to IDLE on the next edge with grant=0 and valid=0.
REQ-019 On every owner change, whether by release or rotation, the block SHALL set ptr = old owner + 1 (mod 4).
REQ-020 Requests from non-owners SHALL NOT change the grant before release or forced rotation.
REQ-021 The block SHALL update out as: out(t+1) = data(t)[select(t)] when valid(t)=1, else 0; out lags the grant by one cycle.
REQ-022 grant SHALL never have more than one bit set, and select SHALL equal the index of the set bit whenever valid=1.
REQ-023 When req toggles in the same cycle as a forced rotation, evaluation SHALL use the sampled req of that cycle only.

Reset
REQ-024 On any edge with rst=1, the block SHALL set grant=0000, select=00, valid=0, out=0, ptr=0, cnt=0 and state=IDLE, regardless of req and data.
REQ-025 rst asserted mid-grant SHALL drop ownership on that edge, with no completion of the hold period.
REQ-026 After rst deasserts, the first arbitration SHALL start from requester 0.

Verification
REQ-027 Reset, then req=0001 -> after 1 edge: grant=0001, select=00, valid=1.
REQ-028 MAX_HOLD=4, req=1111 held -> grant 0001 for 4 cycles, 0010 for 4, 0100 for 4, 1000 for 4, then 0001 again.
REQ-029 Owner 0 granted, req goes 0001->0100 after 2 cycles -> next edge grant=0100, select=10, with no valid gap.
REQ-030 req=1000 held 10 cycles alone -> grant stays 1000 throughout; cnt saturates at 4; no rotation.
REQ-031 Owner 2, data=0100 -> out=1 one cycle later; data=0000 -> out=0 one cycle later; with valid=0, out=0.
REQ-032 rst=1 during grant=0010 with req=1111 -> next edge all outputs zero; after release, first grant=0001.

Source files
------------

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: four-requester round-robin arbiter driving a shared 4:1
// data-bit mux. The owner keeps the path until it releases, or until it has
// held for MAX_HOLD cycles while someone else is waiting. All outputs are
// registered; the muxed data bit lags the grant by one cycle.
module mux_arbiter4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] data,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       valid,
    output logic       out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

    state_t     state_reg,  state_next;
    logic [1:0] ptr_reg,    ptr_next;
    logic [3:0] cnt_reg,    cnt_next;
    logic [3:0] grant_reg,  grant_next;
    logic [1:0] select_reg, select_next;
    logic       valid_reg,  valid_next;
    logic       out_reg,    out_next;

    // Request bits re-ordered into search order: from the pointer (idle
    // arbitration) and from the slot after the current owner (hand-over).
    logic [1:0] idx_from_ptr [4];
    logic [3:0] req_from_ptr;
    logic [1:0] idx_from_own [3];
    logic [2:0] req_from_own;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ptr_order
            assign idx_from_ptr[gi] = ptr_reg + 2'(gi);
            assign req_from_ptr[gi] = req[idx_from_ptr[gi]];
        end
        for (gi = 0; gi < 3; gi++) begin : g_own_order
            assign idx_from_own[gi] = select_reg + 2'd1 + 2'(gi);
            assign req_from_own[gi] = req[idx_from_own[gi]];
        end
    endgenerate

    logic       ptr_found;
    logic [1:0] ptr_win;
    logic       own_found;
    logic [1:0] own_win;
    logic       owner_req;
    logic       others_req;

    // Priority pick: the earliest requester in each search order wins.
    always_comb begin
        ptr_found = 1'b0;
        ptr_win   = 2'd0;
        own_found = 1'b0;
        own_win   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_from_ptr[i]) begin
                ptr_found = 1'b1;
                ptr_win   = idx_from_ptr[i];
            end
        end
        for (int i = 2; i >= 0; i--) begin
            if (req_from_own[i]) begin
                own_found = 1'b1;
                own_win   = idx_from_own[i];
            end
        end
        owner_req  = req[select_reg];
        others_req = |req_from_own;
    end

    // State register: arbitration state, bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= 2'd0;
            cnt_reg    <= 4'd0;
            grant_reg  <= 4'd0;
            select_reg <= 2'd0;
            valid_reg  <= 1'b0;
            out_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            grant_reg  <= grant_next;
            select_reg <= select_next;
            valid_reg  <= valid_next;
            out_reg    <= out_next;
        end
    end

    // Next-state logic: idle arbitration, hold/saturate, release and rotation.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        grant_next  = grant_reg;
        select_next = select_reg;
        valid_next  = valid_reg;
        out_next    = valid_reg ? data[select_reg] : 1'b0;
        case (state_reg)
            IDLE: begin
                if (ptr_found) begin
                    state_next  = GRANT;
                    select_next = ptr_win;
                    grant_next  = 4'b0001 << ptr_win;
                    valid_next  = 1'b1;
                    cnt_next    = 4'd1;
                end else begin
                    grant_next = 4'd0;
                    valid_next = 1'b0;
                end
            end
            GRANT: begin
                if (owner_req && ((cnt_reg < MAX_CNT) || !others_req)) begin
                    // Owner keeps the path; the counter sticks at the limit.
                    if (cnt_reg < MAX_CNT) begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (own_found) begin
                    // Hand-over without an idle bubble (release or rotation).
                    select_next = own_win;
                    grant_next  = 4'b0001 << own_win;
                    valid_next  = 1'b1;
                    cnt_next    = 4'd1;
                    ptr_next    = select_reg + 2'd1;
                end else begin
                    // Owner released and nobody else is waiting.
                    state_next = IDLE;
                    grant_next = 4'd0;
                    valid_next = 1'b0;
                    cnt_next   = 4'd0;
                    ptr_next   = select_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'd0;
                valid_next = 1'b0;
            end
        endcase
    end

    // Output logic: ports come straight from their registers.
    always_comb begin
        grant  = grant_reg;
        select = select_reg;
        valid  = valid_reg;
        out    = out_reg;
    end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Directed testbench for mux_arbiter4 (MAX_HOLD = 4).
module tb_mux_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] grant;
    logic [1:0] select;
    logic       valid;
    logic       out;

    int n_cmp = 0;
    int n_err = 0;

    mux_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .grant  (grant),
        .select (select),
        .valid  (valid),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        data = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        data = 4'b1111;
        step();
        step();
        n_cmp++;
        if ({grant, select, valid, out} !== 8'b0) begin
            $display("FAIL reset grant=%b select=%b valid=%b out=%b expected all zero",
                     grant, select, valid, out);
            n_err++;
        end
        rst = 1'b0;
        $display("test_reset: grant=%b select=%b valid=%b out=%b", grant, select, valid, out);
    endtask

    task automatic test_first_grant();
        do_reset();
        req = 4'b0001;
        step();
        n_cmp++;
        if ({grant, select, valid} !== {4'b0001, 2'b00, 1'b1}) begin
            $display("FAIL first_grant grant=%b select=%b valid=%b expected 0001/00/1",
                     grant, select, valid);
            n_err++;
        end
        $display("test_first_grant: grant=%b select=%b valid=%b", grant, select, valid);
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_s = 2'(((k - 1) / 4) % 4);
            exp_g = 4'b0001 << exp_s;
            n_cmp++;
            if ({grant, select, valid} !== {exp_g, exp_s, 1'b1}) begin
                $display("FAIL rotation cycle %0d grant=%b select=%b valid=%b expected %b/%b/1",
                         k, grant, select, valid, exp_g, exp_s);
                n_err++;
            end
            $display("test_rotation: cycle %0d grant=%b select=%b", k, grant, select);
        end
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b0001;
        step();
        step();
        n_cmp++;
        if ({grant, valid} !== {4'b0001, 1'b1}) begin
            $display("FAIL release_hold grant=%b valid=%b expected 0001/1", grant, valid);
            n_err++;
        end
        req = 4'b0100;
        step();
        n_cmp++;
        if ({grant, select, valid} !== {4'b0100, 2'b10, 1'b1}) begin
            $display("FAIL release_handover grant=%b select=%b valid=%b expected 0100/10/1",
                     grant, select, valid);
            n_err++;
        end
        $display("test_release: grant=%b select=%b valid=%b", grant, select, valid);
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if ({grant, select, valid} !== {4'b1000, 2'b11, 1'b1}) begin
                $display("FAIL saturate cycle %0d grant=%b select=%b expected 1000/11",
                         k, grant, select);
                n_err++;
            end
        end
        // Counter is at the limit, so a new requester forces rotation at once.
        req = 4'b1001;
        step();
        n_cmp++;
        if ({grant, select} !== {4'b0001, 2'b00}) begin
            $display("FAIL saturate_rotate grant=%b select=%b expected 0001/00", grant, select);
            n_err++;
        end
        $display("test_saturate: grant=%b select=%b", grant, select);
    endtask

    task automatic test_nonowner();
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b0011;
        step();
        n_cmp++;
        if ({grant, select} !== {4'b0010, 2'b01}) begin
            $display("FAIL nonowner grant=%b select=%b expected 0010/01", grant, select);
            n_err++;
        end
        $display("test_nonowner: grant=%b select=%b", grant, select);
    endtask

    task automatic test_out();
        logic [4:0] vec_data [6];
        logic [3:0] vec_req  [6];
        logic       vec_out  [6];
        vec_req  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        vec_data = '{5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b01111, 5'b01111};
        // Out reflects the previous cycle's owner bit, and is 0 when not valid.
        vec_out  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req  = vec_req[k];
            data = vec_data[k][3:0];
            step();
            n_cmp++;
            if (out !== vec_out[k]) begin
                $display("FAIL out step %0d out=%b expected %b", k, out, vec_out[k]);
                n_err++;
            end
            $display("test_out: step %0d grant=%b valid=%b out=%b", k, grant, valid, out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req  = 4'b1111;
        data = 4'b1111;
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (grant !== 4'b0010) begin
            $display("FAIL reset_mid_pre grant=%b expected 0010", grant);
            n_err++;
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({grant, select, valid, out} !== 8'b0) begin
            $display("FAIL reset_mid grant=%b select=%b valid=%b out=%b expected all zero",
                     grant, select, valid, out);
            n_err++;
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({grant, select, valid} !== {4'b0001, 2'b00, 1'b1}) begin
            $display("FAIL reset_mid_after grant=%b select=%b expected 0001/00", grant, select);
            n_err++;
        end
        $display("test_reset_mid: grant=%b select=%b valid=%b", grant, select, valid);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        n_cmp++;
        if ({grant, select, valid} !== {4'b0000, 2'b00, 1'b0}) begin
            $display("FAIL idle_after_release grant=%b select=%b valid=%b expected 0000/00/0",
                     grant, select, valid);
            n_err++;
        end
        // Pointer moved past the released owner, so requester 1 wins next.
        req = 4'b1111;
        step();
        n_cmp++;
        if ({grant, select} !== {4'b0010, 2'b01}) begin
            $display("FAIL ptr_advance grant=%b select=%b expected 0010/01", grant, select);
            n_err++;
        end
        $display("test_back_to_back: grant=%b select=%b", grant, select);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = 4'b0000;
        test_reset();
        test_first_grant();
        test_rotation();
        test_release();
        test_saturate();
        test_nonowner();
        test_out();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
